// File: rtl/decode_pkg.sv
// Shared types and constants for the ID/EX pipeline register.
// Holds the bubble instruction, control bundle layout and field positions.
package decode_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    localparam int BCNT_W = 3;
    localparam int CTRL_W_DEF = 16;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       br_un;
        logic       asel;
        logic       bsel;
        logic       lsu_wren;
        logic [1:0] slt_sl;
        logic [1:0] wb_sel;
        logic       rd_wren;
        logic [2:0] ctrl;
    } decode_ctrl_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/decode_hazard_unit.sv
// Load-use hazard compare and bubble counter for the ID/EX register.
// Produces the upstream stall and the "load a bubble this cycle" strobe.
module decode_hazard_unit
    import decode_pkg::*;
#(
    parameter int REG_AW           = 5,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up_vld,
    input  logic              dn_vld,
    input  logic              held_load,
    input  logic [REG_AW-1:0] held_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic              adv,
    input  logic              flush,
    output logic              stall,
    output logic              bubble
);

    logic [BCNT_W-1:0] bcnt;
    logic              hz;
    logic              busy;
    logic              rs1_hit;
    logic              rs2_hit;

    assign rs1_hit = rs1_used & (rs1 == held_rd);
    assign rs2_hit = rs2_used & (rs2 == held_rd);

    assign hz = up_vld & dn_vld & held_load
              & (held_rd != '0)
              & (rs1_hit | rs2_hit);

    assign busy  = (bcnt != '0);
    assign stall = hz | busy;

    // A bubble is any advance that does not carry a new instruction.
    assign bubble = adv & ~flush & ~(up_vld & ~stall);

    // Count down the extra bubbles owed after a load-use hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt <= '0;
        end else if (flush) begin
            bcnt <= '0;
        end else if (adv & hz) begin
            bcnt <= BCNT_W'(LOAD_USE_BUBBLES - 1);
        end else if (adv & busy) begin
            bcnt <= bcnt - 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage_reg.sv
// ID/EX pipeline register with valid/ready, load-use bubbles and WB bypass.
// Optional perf counters are built when DECODE_STAGE_PERF_EN is defined.
module decode_stage_reg #(
    parameter int          XLEN             = 32,
    parameter int          CTRL_W           = 16,
    parameter int          REG_AW           = 5,
    parameter int          LOAD_USE_BUBBLES = 1,
    parameter logic [31:0] NOP_INST         = decode_pkg::NOP_INST
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_up_vld,
    output logic              o_up_rdy,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [31:0]       i_inst,
    input  logic [XLEN-1:0]   i_rs1_data,
    input  logic [XLEN-1:0]   i_rs2_data,
    input  logic [XLEN-1:0]   i_imm,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_rs1_used,
    input  logic              i_rs2_used,
    input  logic              i_is_load,
    input  logic [REG_AW-1:0] i_wb_rd_addr,
    input  logic [XLEN-1:0]   i_wb_rd_data,
    input  logic              i_wb_rd_wren,
    input  logic              i_flush,
    output logic              o_dn_vld,
    input  logic              i_dn_rdy,
    output logic [XLEN-1:0]   o_pc,
    output logic [XLEN-1:0]   o_rs1_data,
    output logic [XLEN-1:0]   o_rs2_data,
    output logic [XLEN-1:0]   o_imm,
    output logic [31:0]       o_inst,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_is_load,
    output logic [REG_AW-1:0] o_rs1_addr_hz,
    output logic [REG_AW-1:0] o_rs2_addr_hz
`ifdef DECODE_STAGE_PERF_EN
    ,
    output logic [31:0]       o_perf_stall_cyc,
    output logic [31:0]       o_perf_bubbles,
    output logic [31:0]       o_perf_flushes
`endif
);

    import decode_pkg::*;

    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] held_rd;
    logic [REG_AW-1:0] held_rs1;
    logic [REG_AW-1:0] held_rs2;

    logic              adv;
    logic              stall;
    logic              bubble;
    logic              xfer;

    logic              wb_ok;
    logic              cap_hit1;
    logic              cap_hit2;
    logic              hold_hit1;
    logic              hold_hit2;
    logic [XLEN-1:0]   cap_rs1;
    logic [XLEN-1:0]   cap_rs2;

    assign rs1_addr = i_inst[RS1_LSB +: REG_AW];
    assign rs2_addr = i_inst[RS2_LSB +: REG_AW];
    assign held_rd  = o_inst[RD_LSB  +: REG_AW];
    assign held_rs1 = o_inst[RS1_LSB +: REG_AW];
    assign held_rs2 = o_inst[RS2_LSB +: REG_AW];

    assign o_rs1_addr_hz = rs1_addr;
    assign o_rs2_addr_hz = rs2_addr;

    assign adv      = ~o_dn_vld | i_dn_rdy;
    assign o_up_rdy = adv & ~stall & ~i_flush;
    assign xfer     = i_up_vld & o_up_rdy;

    // x0 is hardwired, so a write to it never forwards.
    assign wb_ok     = i_wb_rd_wren & (i_wb_rd_addr != '0);
    assign cap_hit1  = wb_ok & (i_wb_rd_addr == rs1_addr);
    assign cap_hit2  = wb_ok & (i_wb_rd_addr == rs2_addr);
    assign hold_hit1 = wb_ok & (i_wb_rd_addr == held_rs1);
    assign hold_hit2 = wb_ok & (i_wb_rd_addr == held_rs2);

    assign cap_rs1 = cap_hit1 ? i_wb_rd_data : i_rs1_data;
    assign cap_rs2 = cap_hit2 ? i_wb_rd_data : i_rs2_data;

    decode_hazard_unit #(
        .REG_AW           (REG_AW),
        .LOAD_USE_BUBBLES (LOAD_USE_BUBBLES)
    ) u_hazard (
        .clk       (i_clk),
        .reset     (i_reset),
        .up_vld    (i_up_vld),
        .dn_vld    (o_dn_vld),
        .held_load (o_is_load),
        .held_rd   (held_rd),
        .rs1       (rs1_addr),
        .rs2       (rs2_addr),
        .rs1_used  (i_rs1_used),
        .rs2_used  (i_rs2_used),
        .adv       (adv),
        .flush     (i_flush),
        .stall     (stall),
        .bubble    (bubble)
    );

    // Stage entry: flush > transfer > bubble > hold with WB refresh.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_dn_vld   <= 1'b0;
            o_pc       <= '0;
            o_inst     <= NOP_INST;
            o_rs1_data <= '0;
            o_rs2_data <= '0;
            o_imm      <= '0;
            o_ctrl     <= '0;
            o_is_load  <= 1'b0;
        end else if (i_flush) begin
            o_dn_vld  <= 1'b0;
            o_inst    <= NOP_INST;
            o_ctrl    <= '0;
            o_is_load <= 1'b0;
        end else if (xfer) begin
            o_dn_vld   <= 1'b1;
            o_pc       <= i_pc;
            o_inst     <= i_inst;
            o_rs1_data <= cap_rs1;
            o_rs2_data <= cap_rs2;
            o_imm      <= i_imm;
            o_ctrl     <= i_ctrl;
            o_is_load  <= i_is_load;
        end else if (bubble) begin
            o_dn_vld  <= 1'b0;
            o_inst    <= NOP_INST;
            o_ctrl    <= '0;
            o_is_load <= 1'b0;
        end else if (o_dn_vld) begin
            if (hold_hit1) begin
                o_rs1_data <= i_wb_rd_data;
            end
            if (hold_hit2) begin
                o_rs2_data <= i_wb_rd_data;
            end
        end
    end

`ifdef DECODE_STAGE_PERF_EN
    // Saturating counters for upstream stalls, load-use bubbles, flushes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_perf_stall_cyc <= '0;
            o_perf_bubbles   <= '0;
            o_perf_flushes   <= '0;
        end else begin
            if (i_up_vld & ~o_up_rdy) begin
                o_perf_stall_cyc <= sat_inc(o_perf_stall_cyc);
            end
            if (bubble & stall) begin
                o_perf_bubbles <= sat_inc(o_perf_bubbles);
            end
            if (i_flush) begin
                o_perf_flushes <= sat_inc(o_perf_flushes);
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage_reg.sv
// Bench for decode_stage_reg: three copies with 1, 2 and 4 load-use
// bubbles share one stimulus stream and are checked against a model.
module tb_decode_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        up_vld, flush, dn_rdy;
    logic        rs1_used, rs2_used, ld_in, wb_wren;
    logic [31:0] pc, inst, rs1_d, rs2_d, imm, wb_data;
    logic [15:0] ctrl;
    logic [4:0]  wb_addr;

    logic        up_rdy [3];
    logic        dn_vld [3];
    logic        o_ld   [3];
    logic [31:0] o_pc   [3];
    logic [31:0] o_inst [3];
    logic [31:0] o_rs1  [3];
    logic [31:0] o_rs2  [3];
    logic [31:0] o_imm  [3];
    logic [15:0] o_ctrl [3];
    logic [4:0]  o_a1   [3];
    logic [4:0]  o_a2   [3];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        decode_stage_reg #(
            .LOAD_USE_BUBBLES((g == 0) ? 1 : ((g == 1) ? 2 : 4))
        ) u_dut (
            .i_clk         (clk),
            .i_reset       (reset),
            .i_up_vld      (up_vld),
            .o_up_rdy      (up_rdy[g]),
            .i_pc          (pc),
            .i_inst        (inst),
            .i_rs1_data    (rs1_d),
            .i_rs2_data    (rs2_d),
            .i_imm         (imm),
            .i_ctrl        (ctrl),
            .i_rs1_used    (rs1_used),
            .i_rs2_used    (rs2_used),
            .i_is_load     (ld_in),
            .i_wb_rd_addr  (wb_addr),
            .i_wb_rd_data  (wb_data),
            .i_wb_rd_wren  (wb_wren),
            .i_flush       (flush),
            .o_dn_vld      (dn_vld[g]),
            .i_dn_rdy      (dn_rdy),
            .o_pc          (o_pc[g]),
            .o_rs1_data    (o_rs1[g]),
            .o_rs2_data    (o_rs2[g]),
            .o_imm         (o_imm[g]),
            .o_inst        (o_inst[g]),
            .o_ctrl        (o_ctrl[g]),
            .o_is_load     (o_ld[g]),
            .o_rs1_addr_hz (o_a1[g]),
            .o_rs2_addr_hz (o_a2[g])
        );
    end

    task automatic chk(input string nm, input int k,
                       input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d actual=%0h required=%0h",
                     nm, k, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        bit          vld;
        logic [31:0] pc, inst, r1, r2, imm;
        logic [15:0] ctrl;
        bit          ld;
        int          pend;
    } ent_t;

    ent_t m [3];

    function automatic int lubk(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    function automatic ent_t idle_ent();
        ent_t e;
        e.vld = 0; e.pc = 0; e.inst = NOP; e.r1 = 0; e.r2 = 0;
        e.imm = 0; e.ctrl = 0; e.ld = 0; e.pend = 0;
        return e;
    endfunction

    function automatic logic [31:0] wbfwd(input logic [4:0] a,
                                          input logic [31:0] d);
        if (wb_wren && wb_addr != 0 && wb_addr == a) return wb_data;
        return d;
    endfunction

    function automatic bit load_use(input int k);
        logic [31:0] w;
        logic [4:0]  rd;
        w  = m[k].inst;
        rd = w[11:7];
        if (!(up_vld && m[k].vld && m[k].ld) || rd == 0) return 0;
        return (rs1_used && inst[19:15] == rd) ||
               (rs2_used && inst[24:20] == rd);
    endfunction

    function automatic bit exp_rdy(input int k);
        return (!m[k].vld || dn_rdy) && !load_use(k)
               && m[k].pend == 0 && !flush;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit go, hz, take;
            logic [31:0] w;
            go   = !m[k].vld || dn_rdy;
            hz   = load_use(k);
            take = up_vld && exp_rdy(k);
            w    = m[k].inst;
            if (reset) begin
                m[k] = idle_ent();
            end else if (flush) begin
                m[k].vld = 0; m[k].inst = NOP; m[k].ctrl = 0;
                m[k].ld = 0; m[k].pend = 0;
            end else if (take) begin
                m[k].vld = 1; m[k].pc = pc; m[k].inst = inst;
                m[k].r1 = wbfwd(inst[19:15], rs1_d);
                m[k].r2 = wbfwd(inst[24:20], rs2_d);
                m[k].imm = imm; m[k].ctrl = ctrl; m[k].ld = ld_in;
            end else if (go) begin
                if (hz) m[k].pend = lubk(k) - 1;
                else if (m[k].pend > 0) m[k].pend--;
                m[k].vld = 0; m[k].inst = NOP; m[k].ctrl = 0;
                m[k].ld = 0;
            end else if (m[k].vld) begin
                m[k].r1 = wbfwd(w[19:15], m[k].r1);
                m[k].r2 = wbfwd(w[24:20], m[k].r2);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk("up_rdy", k, 64'(up_rdy[k]), 64'(exp_rdy(k)));
                chk("dn_vld", k, 64'(dn_vld[k]), 64'(m[k].vld));
                chk("pc_inst", k, {o_pc[k], o_inst[k]},
                    {m[k].pc, m[k].inst});
                chk("rs_data", k, {o_rs1[k], o_rs2[k]},
                    {m[k].r1, m[k].r2});
                chk("imm_ctrl_ld", k,
                    64'({o_imm[k], o_ctrl[k], o_ld[k]}),
                    64'({m[k].imm, m[k].ctrl, m[k].ld}));
                chk("addr_hz", k, 64'({o_a1[k], o_a2[k]}),
                    64'({inst[19:15], inst[24:20]}));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        up_vld = 0; flush = 0; dn_rdy = 1;
        wb_wren = 0; wb_addr = 0; wb_data = 0;
        rs1_used = 0; rs2_used = 0; ld_in = 0;
    endtask

    task automatic offer(input logic [31:0] p, input logic [31:0] ins,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] im, input logic [15:0] c,
                         input logic u1, input logic u2, input logic ld);
        up_vld = 1; pc = p; inst = ins; rs1_d = d1; rs2_d = d2;
        imm = im; ctrl = c; rs1_used = u1; rs2_used = u2; ld_in = ld;
    endtask

    initial begin
        quiet();
        pc = 0; inst = NOP; rs1_d = 0; rs2_d = 0; imm = 0; ctrl = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        chk_en = 1;

        // reset state
        for (int k = 0; k < 3; k++) begin
            chk("rst_vld", k, 64'(dn_vld[k]), 64'd0);
            chk("rst_inst", k, 64'(o_inst[k]), 64'h13);
            chk("rst_ctrl", k, 64'(o_ctrl[k]), 64'd0);
        end
        #1;
        for (int k = 0; k < 3; k++) chk("rst_rdy", k, 64'(up_rdy[k]), 64'd1);

        // back-to-back addi x1,x0,5 ; addi x2,x1,1
        offer(32'h100, 32'h0050_0093, 0, 0, 5, 16'h0011, 1, 0, 0);
        #1;
        for (int k = 0; k < 3; k++) chk("b2b_rdy0", k, 64'(up_rdy[k]), 64'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("b2b_vld0", k, 64'(dn_vld[k]), 64'd1);
            chk("b2b_pc0", k, 64'(o_pc[k]), 64'h100);
            chk("b2b_inst0", k, 64'(o_inst[k]), 64'h0050_0093);
        end
        offer(32'h104, 32'h0010_8113, 5, 0, 1, 16'h0012, 1, 0, 0);
        #1;
        for (int k = 0; k < 3; k++) chk("b2b_rdy1", k, 64'(up_rdy[k]), 64'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("b2b_pc1", k, 64'(o_pc[k]), 64'h104);
            chk("b2b_inst1", k, 64'(o_inst[k]), 64'h0010_8113);
        end

        // load-use: lw x5,0(x2) then add x6,x5,x7
        offer(32'h108, 32'h0001_2283, 32'h10, 0, 0, 16'h0021, 1, 0, 1);
        tick();
        for (int k = 0; k < 3; k++) chk("lu_isld", k, 64'(o_ld[k]), 64'd1);
        offer(32'h10c, 32'h0072_8333, 32'h55, 32'h77, 0, 16'h0031, 1, 1, 0);
        #1;
        for (int k = 0; k < 3; k++) chk("lu_rdy_hz", k, 64'(up_rdy[k]), 64'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("lu_bub_vld", k, 64'(dn_vld[k]), 64'd0);
            chk("lu_bub_inst", k, 64'(o_inst[k]), 64'h13);
            chk("lu_bub_pc", k, 64'(o_pc[k]), 64'h108);
        end
        #1;
        chk("lu_rdy_b1", 0, 64'(up_rdy[0]), 64'd1);
        chk("lu_rdy_b1", 1, 64'(up_rdy[1]), 64'd0);
        chk("lu_rdy_b1", 2, 64'(up_rdy[2]), 64'd0);
        tick();
        chk("lu_add_vld", 0, 64'(dn_vld[0]), 64'd1);
        chk("lu_add_pc", 0, 64'(o_pc[0]), 64'h10c);
        chk("lu_bub2_vld", 1, 64'(dn_vld[1]), 64'd0);
        #1;
        chk("lu_rdy_b2", 1, 64'(up_rdy[1]), 64'd1);
        chk("lu_rdy_b2", 2, 64'(up_rdy[2]), 64'd0);
        tick();
        chk("lu_add_vld", 1, 64'(dn_vld[1]), 64'd1);
        chk("lu_add_pc", 1, 64'(o_pc[1]), 64'h10c);
        tick();
        tick();
        chk("lu_add_vld", 2, 64'(dn_vld[2]), 64'd1);
        chk("lu_add_pc", 2, 64'(o_pc[2]), 64'h10c);
        quiet();
        tick();

        // downstream stall with WB refresh of held rs1=x3
        offer(32'h200, 32'h0001_84B3, 32'h1111, 32'h2222, 32'h33,
              16'h0041, 1, 1, 0);
        tick();
        up_vld = 0; dn_rdy = 0;
        tick();
        wb_wren = 1; wb_addr = 3; wb_data = 32'hDEAD;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("st_vld", k, 64'(dn_vld[k]), 64'd1);
            chk("st_rs1", k, 64'(o_rs1[k]), 64'hDEAD);
            chk("st_rs2", k, 64'(o_rs2[k]), 64'h2222);
            chk("st_pc", k, 64'(o_pc[k]), 64'h200);
            chk("st_imm", k, 64'(o_imm[k]), 64'h33);
        end
        wb_wren = 0;
        tick();
        for (int k = 0; k < 3; k++) chk("st_rs1_kept", k, 64'(o_rs1[k]), 64'hDEAD);
        quiet();
        tick();

        // capture bypass, then WB to x0 ignored
        offer(32'h300, 32'h0042_0433, 32'h5555, 32'h5555, 0, 16'h0051, 1, 1, 0);
        wb_wren = 1; wb_addr = 4; wb_data = 32'h1234;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("cap_rs1", k, 64'(o_rs1[k]), 64'h1234);
            chk("cap_rs2", k, 64'(o_rs2[k]), 64'h1234);
        end
        offer(32'h304, 32'h0050_0093, 0, 0, 5, 16'h0011, 1, 0, 0);
        wb_addr = 0; wb_data = 32'hBEEF;
        tick();
        for (int k = 0; k < 3; k++) chk("cap_x0", k, 64'(o_rs1[k]), 64'd0);

        // lw x0 never raises a hazard
        quiet();
        offer(32'h308, 32'h0001_2003, 0, 0, 0, 16'h0061, 1, 0, 1);
        tick();
        offer(32'h30c, 32'h0050_0093, 0, 0, 5, 16'h0011, 1, 0, 0);
        #1;
        for (int k = 0; k < 3; k++) chk("x0_nohz", k, 64'(up_rdy[k]), 64'd1);
        tick();

        // flush while the bubble counter is still running
        offer(32'h400, 32'h0001_2283, 32'h10, 0, 0, 16'h0021, 1, 0, 1);
        tick();
        offer(32'h404, 32'h0072_8333, 32'h55, 32'h77, 0, 16'h0031, 1, 1, 0);
        tick();
        #1;
        chk("fl_busy", 2, 64'(up_rdy[2]), 64'd0);
        tick();
        flush = 1;
        #1;
        for (int k = 0; k < 3; k++) chk("fl_rdy", k, 64'(up_rdy[k]), 64'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("fl_vld", k, 64'(dn_vld[k]), 64'd0);
            chk("fl_inst", k, 64'(o_inst[k]), 64'h13);
        end
        flush = 0;
        #1;
        for (int k = 0; k < 3; k++) chk("fl_rdy_after", k, 64'(up_rdy[k]), 64'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("fl_take_vld", k, 64'(dn_vld[k]), 64'd1);
            chk("fl_take_pc", k, 64'(o_pc[k]), 64'h404);
        end

        quiet();
        repeat (3) tick();
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
